// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector.
// Per-channel mode encodings and a constant clog2 used for counter widths.
package edge_det_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Bits needed to hold values 0..v-1. Never returns less than 1 so that
  // counters for tiny ranges still get a legal width.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, debounce filter, mode-qualified
// edge detect, registered pulse, sticky pending flag.
// Optional saturating edge counter built only when EDGE_CNT_EN is defined;
// otherwise cnt is tied to zero and no counter flops exist.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             level,
  output logic             pulse,
  output logic             pend,
  output logic [CNT_W-1:0] cnt
);

  localparam int              DB_W    = clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DB_W-1:0]        db_cnt;
  logic                   toggle;
  logic                   rise_en;
  logic                   fall_en;
  logic                   qual;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: bring the async pin into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
  end

  // Decode mode into rise/fall enables and qualify the toggle. Mode is live,
  // so a change takes effect on the very next toggle.
  always_comb begin
    rise_en = 1'b0;
    fall_en = 1'b0;
    case (mode)
      MODE_OFF:  begin rise_en = 1'b0; fall_en = 1'b0; end
      MODE_RISE: begin rise_en = 1'b1; fall_en = 1'b0; end
      MODE_FALL: begin rise_en = 1'b0; fall_en = 1'b1; end
      MODE_BOTH: begin rise_en = 1'b1; fall_en = 1'b1; end
      default:   begin rise_en = 1'b0; fall_en = 1'b0; end
    endcase
    toggle = (s != level) && (db_cnt == DB_LAST);
    qual   = (toggle && s && rise_en) || (toggle && !s && fall_en);
  end

  // Debounce: count consecutive samples disagreeing with the stable level;
  // any agreeing sample restarts the count, the DEBOUNCE-th flips the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (s == level) begin
      db_cnt <= '0;
    end else if (toggle) begin
      level  <= s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Registered pulse and sticky pending; a same-cycle edge beats clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= 1'b0;
      pend  <= 1'b0;
    end else begin
      pulse <= qual;
      pend  <= qual | (pend & ~clr);
    end
  end

`ifdef EDGE_CNT_EN
  // Saturating qualified-edge counter; clr with an edge leaves a count of 1.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= qual ? CNT_W'(1) : '0;
    else if (qual && (cnt != {CNT_W{1'b1}}))
                          cnt <= cnt + CNT_W'(1);
  end
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/edge_det_multi.sv
// Multi-channel edge detector top: N independent channels plus a
// registered OR of the pending flags as the controller interrupt.
// Optional feature macro: EDGE_CNT_EN (per-channel saturating edge counters).
module edge_det_multi #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       sig_in,
  input  logic [2*N-1:0]     mode,
  input  logic [N-1:0]       clr,
  output logic [N-1:0]       level_out,
  output logic [N-1:0]       edge_pulse,
  output logic [N-1:0]       pending,
  output logic               irq,
  output logic [N*CNT_W-1:0] edge_cnt
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .sig  (sig_in[i]),
      .mode (mode[2*i +: 2]),
      .clr  (clr[i]),
      .level(level_out[i]),
      .pulse(edge_pulse[i]),
      .pend (pending[i]),
      .cnt  (edge_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Interrupt lags pending by one cycle so it comes straight off a flop.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |pending;
  end

endmodule

// File: doc/edge_det_multi.md
Name: edge_det_multi

Overview:
Parametrised multi-channel edge detector, the successor to the single-bit positive/negative edge detectors. Each channel takes an asynchronous input through a synchroniser, a debounce filter and a per-channel mode-selected edge detector. Each channel produces a registered one-cycle pulse and a sticky pending flag with a clear input. Sits between board-level status/strobe pins and the FT601 control logic; the aggregated irq feeds the controller.

Parameters:
N, 4, number of channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE, 4, consecutive agreeing samples required before the stable level changes (>=1; 1 = no filtering)
CNT_W, 8, edge-counter width per channel (used only with EDGE_CNT_EN)

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
sig_in  in  N  asynchronous input signals
mode  in  2*N  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr  in  N  per-channel clear of pending/count, sampled each cycle
level_out  out  N  debounced stable level
edge_pulse  out  N  one-cycle pulse per qualified edge
pending  out  N  sticky qualified-edge flag
irq  out  1  OR of pending
edge_cnt  out  N*CNT_W  per-channel saturating edge count

Behaviour:
- Reset (rst=1 at posedge): sync chain, stable level, debounce counter, edge_pulse, pending and edge_cnt all clear to 0. irq=0 the cycle after. An in-progress debounce is aborted and pending events are discarded.
- Synchroniser: SYNC_STAGES flops; s = last stage.
- Debounce: the counter counts consecutive edges where s != stable. It resets to 0 on any edge where s == stable. On the DEBOUNCE-th consecutive differing edge, stable <= s and the counter returns to 0. Counter width is clog2(DEBOUNCE+1).
- Edge qualification, evaluated on the same edge that stable toggles:
  - rise = toggle & s
  - fall = toggle & ~s
  - qualified = (rise & mode[0]) | (fall & mode[1])
  - Mode is sampled live. With mode 00, stable and level_out still track but no pulse or pending is generated.
- edge_pulse is registered and high for exactly one cycle per qualified edge. The next edge on a channel needs at least DEBOUNCE cycles, so pulses never merge.
- Latency: sig_in change (setup met) to edge_pulse/level_out high = SYNC_STAGES+DEBOUNCE clk edges. Defaults give 6.
- pending[i]: set by qualified edge, cleared by clr[i]. If both happen in the same cycle, set wins and no event is lost. irq is registered: irq = |pending, one cycle after pending.
- Input high at reset release: stable starts at 0, so a rise is detected after the normal latency.
- A glitch shorter than DEBOUNCE samples produces no change in any output.

Optional Feature:
EDGE_CNT_EN
- Defined: per-channel CNT_W-bit counter increments on each qualified edge and saturates at all-ones. clr[i] zeroes it; clr and a qualified edge in the same cycle give a count of 1.
- Undefined: edge_cnt is tied to 0, no counter flops are built, and the port list is unchanged.

Decomposition:
- Package edge_det_pkg holds:
  - mode encodings MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11
  - a clog2 constant function for counter widths
- Sub-module edge_det_chan: one channel (sync, debounce, detect, pending, optional counter).
- edge_det_multi generates N instances and the registered irq OR.

Test Plan:
- Defaults, mode=01 on ch0, sig_in[0] 0->1 held -> edge_pulse[0] high exactly 1 cycle, 6 edges after change. level_out[0]=1 at the same edge. pending[0]=1, irq=1 one cycle later.
- Ch1 mode=11, 3-cycle high glitch then a clean 20-cycle high pulse -> no output for the glitch, then a rise pulse and a fall pulse, each 1 cycle. With EDGE_CNT_EN, edge_cnt[1]=2.
- Ch2 mode=00, toggle sig_in[2] -> level_out[2] follows; edge_pulse[2], pending[2] and irq stay 0.
- Ch0 pending=1, assert clr[0] on the same cycle as a new qualified edge -> pending[0] stays 1. clr[0] alone next cycle -> 0, then irq=0 a cycle later.
- Ch3 mode=01, EDGE_CNT_EN, CNT_W=8: 300 debounced rises -> edge_cnt[3]=255 (saturated); clr[3] -> 0.
- rst=1 mid-debounce (counter=2) with pending=1 -> all outputs 0 after the reset edge. After release with sig_in held high, a rise is detected 6 edges later.
